// File: rtl/lfsr_seq_ctrl_pkg.sv
// Shared types for the LFSR run sequencer: FSM states and run status codes.
package lfsr_ctrl_pkg;

  localparam int ST_W = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef enum logic [ST_W-1:0] {
    STOP_HIT = 2'd0,
    TIMEOUT  = 2'd1,
    ABORT    = 2'd2,
    BAD_SEED = 2'd3
  } status_e;

endpackage

// File: rtl/lfsr_seq_ctrl_if.sv
// Host config bus carrying one run descriptor with a valid/ready handshake.
interface lfsr_seq_ctrl_if #(
  parameter int NUM_BITS = 49,
  parameter int CNT_W    = 32
);
  logic                i_cfg_vld;
  logic                o_cfg_rdy;
  logic [NUM_BITS-1:0] i_cfg_seed;
  logic [NUM_BITS-1:0] i_cfg_stop;
  logic [CNT_W-1:0]    i_cfg_max_steps;

  modport slave  (input  i_cfg_vld, i_cfg_seed, i_cfg_stop, i_cfg_max_steps,
                  output o_cfg_rdy);
  modport master (output i_cfg_vld, i_cfg_seed, i_cfg_stop, i_cfg_max_steps,
                  input  o_cfg_rdy);
endinterface

// File: rtl/lfsr_sat_counter.sv
// Clearable up-counter that sticks at all-ones instead of wrapping.
module lfsr_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  // clear wins over increment; increment suppressed once saturated
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr)        r_cnt <= '0;
    else if (i_inc && ~&r_cnt) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Run sequencer for an XNOR LFSR: seeds it, steps it under array backpressure,
// and reports why and after how many steps the run ended.
module lfsr_seq_ctrl
  import lfsr_ctrl_pkg::*;
#(
  parameter int NUM_BITS = 49,
  parameter int CNT_W    = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  lfsr_seq_ctrl_if.slave      cfg,
  input  logic                i_abort,
  input  logic                i_sa_rdy,
  output logic                o_lfsr_mode,
  output logic                o_lfsr_en,
  output logic                o_lfsr_vld,
  output logic [NUM_BITS-1:0] o_lfsr_data,
  output logic [NUM_BITS-1:0] o_lfsr_stop,
  input  logic                i_lfsr_done,
  input  logic                i_lfsr_vld,
  output logic                o_busy,
  output logic                o_done,
  output logic [ST_W-1:0]     o_status,
  output logic [CNT_W-1:0]    o_steps,
  output logic [CNT_W-1:0]    o_samples
);
  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_SEED  = SEED;
  localparam logic [2:0] S_RUN   = RUN;
  localparam logic [2:0] S_DRAIN = DRAIN;
  localparam logic [2:0] S_DONE  = DONE;

  logic [2:0]          r_state;
  logic [NUM_BITS-1:0] r_seed;
  logic [NUM_BITS-1:0] r_stop;
  logic [CNT_W-1:0]    r_max;
  logic [ST_W-1:0]     r_status;

  logic [2:0]          w_nxt_state;
  logic [ST_W-1:0]     w_nxt_status;
  logic                w_accept;
  logic                w_stop_cond;
  logic                w_hit;
  logic                w_step_inc;
  logic                w_smp_inc;
  logic [CNT_W-1:0]    w_steps;
  logic [CNT_W-1:0]    w_samples;

  lfsr_sat_counter #(.CNT_W(CNT_W)) u_steps (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_accept), .i_inc(w_step_inc), .o_cnt(w_steps)
  );

  lfsr_sat_counter #(.CNT_W(CNT_W)) u_samples (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_accept), .i_inc(w_smp_inc), .o_cnt(w_samples)
  );

  // next-state, status and LFSR pin decode
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_status = r_status;
    w_accept     = 1'b0;
    w_step_inc   = 1'b0;
    w_smp_inc    = 1'b0;
    o_lfsr_mode  = 1'b0;
    o_lfsr_en    = 1'b0;
    o_lfsr_vld   = 1'b0;
    o_lfsr_data  = '0;
    o_done       = 1'b0;
    // done is ignored at step 0 so a seed equal to the stop code still runs
    w_hit        = i_lfsr_done && (w_steps != '0);
    w_stop_cond  = i_abort || w_hit || ((r_max != '0) && (w_steps == r_max));
    case (r_state)
      S_IDLE: begin
        if (cfg.i_cfg_vld) begin
          w_accept = 1'b1;
          // all-ones is the XNOR lockup state: never load it into the LFSR
          if (&cfg.i_cfg_seed) begin
            w_nxt_state  = S_DONE;
            w_nxt_status = BAD_SEED;
          end else begin
            w_nxt_state  = S_SEED;
            w_nxt_status = STOP_HIT;
          end
        end
      end
      S_SEED: begin
        o_lfsr_vld  = 1'b1;
        o_lfsr_data = r_seed;
        if (i_abort) begin
          w_nxt_state  = S_DRAIN;
          w_nxt_status = ABORT;
        end else begin
          w_nxt_state  = S_RUN;
        end
      end
      S_RUN: begin
        o_lfsr_mode = 1'b1;
        w_smp_inc   = i_lfsr_vld;
        if (w_stop_cond) begin
          w_nxt_state = S_DRAIN;
          if (i_abort)    w_nxt_status = ABORT;
          else if (w_hit) w_nxt_status = STOP_HIT;
          else            w_nxt_status = TIMEOUT;
        end else begin
          o_lfsr_en  = i_sa_rdy;
          w_step_inc = i_sa_rdy;
        end
      end
      S_DRAIN: begin
        // one idle cycle lets the last registered LFSR valid be counted
        o_lfsr_mode = 1'b1;
        w_smp_inc   = i_lfsr_vld;
        w_nxt_state = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_nxt_state = S_IDLE;
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // FSM state, latched descriptor and held status
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_seed   <= '0;
      r_stop   <= '0;
      r_max    <= '0;
      r_status <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_status <= w_nxt_status;
      if (w_accept) begin
        r_seed <= cfg.i_cfg_seed;
        r_stop <= cfg.i_cfg_stop;
        r_max  <= cfg.i_cfg_max_steps;
      end
    end
  end

  assign cfg.o_cfg_rdy = (r_state == S_IDLE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_lfsr_stop   = r_stop;
  assign o_status      = r_status;
  assign o_steps       = w_steps;
  assign o_samples     = w_samples;
endmodule
